// File: rtl/execute_pipe.sv
// Handshaked execute stage: ALU ops with an architectural {CF,ZF,SF,OF} flag register,
// iterative MUL/IMUL when EXECUTE_MUL_EN is defined (otherwise ops 13/14 flag illegal), sticky HALT.
module execute_pipe #(
  parameter int DATA_WIDTH     = 64,
  parameter int MUL_STEP_BITS  = 8,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_op,
  input  logic [DATA_WIDTH-1:0]     in_a,
  input  logic [DATA_WIDTH-1:0]     in_b,
  input  logic [REG_ADDR_WIDTH-1:0] in_dest,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_result,
  output logic [DATA_WIDTH-1:0]     out_result_hi,
  output logic                      out_hi_valid,
  output logic [REG_ADDR_WIDTH-1:0] out_dest,
  output logic                      out_wb_en,
  output logic [3:0]                out_flags,
  output logic                      halted,
  output logic                      illegal,
  output logic [1:0]                dbg_state
);

  localparam int W  = DATA_WIDTH;
  localparam int WP = DATA_WIDTH + 1;
  localparam int W2 = 2 * DATA_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [3:0] OP_MOV  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADC  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SBB  = 4'd4;
  localparam logic [3:0] OP_CMP  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_NEG  = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;
  localparam logic [3:0] OP_DEC  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_IMUL = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  if ((DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) ||
      (DATA_WIDTH % MUL_STEP_BITS) != 0) begin : g_param_err
    $error("execute_pipe: unsupported DATA_WIDTH / MUL_STEP_BITS combination");
  end

  logic [1:0]                state_q, state_d;
  logic                      out_valid_q, out_valid_d;
  logic [W-1:0]              out_result_q, out_result_d;
  logic [W-1:0]              out_hi_q, out_hi_d;
  logic                      out_hi_valid_q, out_hi_valid_d;
  logic [REG_ADDR_WIDTH-1:0] out_dest_q, out_dest_d;
  logic                      out_wb_en_q, out_wb_en_d;
  logic [3:0]                flags_q, flags_d;
  logic                      halted_q, halted_d;
  logic                      illegal_q, illegal_d;

  // Handshake: an op transfers on a rising edge with in_valid && in_ready; a result transfers
  // with out_valid && out_ready. The output register holds one entry and may drain and reload
  // on the same edge, so in_ready looks through a draining result.
  logic out_free;
  logic accept;
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == ST_IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  logic [WP-1:0] add_x, sub_x;
  logic [W-1:0]  alu_res;
  logic [3:0]    alu_flags;
  logic          alu_wb, alu_ill, upd, cf, of;

  always_comb begin
    add_x   = {1'b0, in_a} + {1'b0, in_b} + WP'((in_op == OP_ADC) && flags_q[3]);
    sub_x   = {1'b0, in_a} - {1'b0, in_b} - WP'((in_op == OP_SBB) && flags_q[3]);
    alu_res = '0;
    alu_wb  = 1'b1;
    alu_ill = 1'b0;
    upd     = 1'b1;
    cf      = 1'b0;
    of      = 1'b0;
    case (in_op)
      OP_MOV: begin
        alu_res = in_b;
        upd     = 1'b0;
      end
      OP_ADD, OP_ADC: begin
        alu_res = add_x[W-1:0];
        cf      = add_x[W];
        of      = (in_a[W-1] == in_b[W-1]) && (alu_res[W-1] != in_a[W-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        alu_res = sub_x[W-1:0];
        cf      = sub_x[W];
        of      = (in_a[W-1] != in_b[W-1]) && (alu_res[W-1] != in_a[W-1]);
        alu_wb  = (in_op != OP_CMP);
      end
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_NOT: begin
        alu_res = ~in_a;
        upd     = 1'b0;
      end
      OP_NEG: begin
        alu_res = W'(0) - in_a;
        cf      = |in_a;
        of      = in_a[W-1] && alu_res[W-1];
      end
      OP_INC: begin
        alu_res = in_a + W'(1);
        cf      = flags_q[3];
        of      = !in_a[W-1] && alu_res[W-1];
      end
      OP_DEC: begin
        alu_res = in_a - W'(1);
        cf      = flags_q[3];
        of      = in_a[W-1] && !alu_res[W-1];
      end
      OP_HALT: begin
        alu_wb = 1'b0;
        upd    = 1'b0;
      end
      default: begin
        // MUL/IMUL only reach this path when the multiplier is not built.
        alu_wb  = 1'b0;
        alu_ill = 1'b1;
        upd     = 1'b0;
      end
    endcase
    alu_flags = upd ? {cf, (alu_res == '0), alu_res[W-1], of} : flags_q;
  end

`ifdef EXECUTE_MUL_EN
  localparam int N     = DATA_WIDTH / MUL_STEP_BITS;
  localparam int CNT_W = $clog2(N + 1);

  logic [W2-1:0]             acc_q, acc_d, mcand_q, mcand_d;
  logic [W-1:0]              mplier_q, mplier_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      neg_q, neg_d, msigned_q, msigned_d;
  logic [REG_ADDR_WIDTH-1:0] mdest_q, mdest_d;
  logic [W2-1:0]             mul_full;
  logic [W-1:0]              mul_lo, mul_hi, a_mag, b_mag;
  logic                      mul_done, mul_start, is_signed, mul_ovf;

  assign is_signed = (in_op == OP_IMUL);
  assign a_mag     = (is_signed && in_a[W-1]) ? (W'(0) - in_a) : in_a;
  assign b_mag     = (is_signed && in_b[W-1]) ? (W'(0) - in_b) : in_b;
  assign mul_start = accept && ((in_op == OP_MUL) || (in_op == OP_IMUL));
  assign mul_done  = (state_q == ST_MUL) && (cnt_q == CNT_W'(N));
  // The multiplier works on magnitudes; the sign is applied once at the end.
  assign mul_full  = neg_q ? (W2'(0) - acc_q) : acc_q;
  assign mul_lo    = mul_full[W-1:0];
  assign mul_hi    = mul_full[W2-1:W];
  assign mul_ovf   = msigned_q ? (mul_hi != {W{mul_lo[W-1]}}) : (mul_hi != '0);
`endif

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q && !out_ready;
    out_result_d   = out_result_q;
    out_hi_d       = out_hi_q;
    out_hi_valid_d = out_hi_valid_q;
    out_dest_d     = out_dest_q;
    out_wb_en_d    = out_wb_en_q;
    flags_d        = flags_q;
    halted_d       = halted_q;
    illegal_d      = illegal_q;
`ifdef EXECUTE_MUL_EN
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    msigned_d = msigned_q;
    mdest_d   = mdest_q;
    if (mul_start) begin
      state_d   = ST_MUL;
      acc_d     = '0;
      mcand_d   = {{W{1'b0}}, a_mag};
      mplier_d  = b_mag;
      cnt_d     = '0;
      neg_d     = is_signed && (in_a[W-1] ^ in_b[W-1]);
      msigned_d = is_signed;
      mdest_d   = in_dest;
    end else if (state_q == ST_MUL) begin
      if (!mul_done) begin
        acc_d    = acc_q + (mcand_q * W2'(mplier_q[MUL_STEP_BITS-1:0]));
        mcand_d  = mcand_q << MUL_STEP_BITS;
        mplier_d = mplier_q >> MUL_STEP_BITS;
        cnt_d    = cnt_q + CNT_W'(1);
      end else if (out_free) begin
        state_d        = ST_IDLE;
        out_valid_d    = 1'b1;
        out_result_d   = mul_lo;
        out_hi_d       = mul_hi;
        out_hi_valid_d = 1'b1;
        out_dest_d     = mdest_q;
        out_wb_en_d    = 1'b1;
        illegal_d      = 1'b0;
        flags_d        = {mul_ovf, (mul_lo == '0), mul_lo[W-1], mul_ovf};
      end
    end else
`endif
    if (accept) begin
      out_valid_d    = 1'b1;
      out_result_d   = alu_res;
      out_hi_d       = '0;
      out_hi_valid_d = 1'b0;
      out_dest_d     = in_dest;
      out_wb_en_d    = alu_wb;
      illegal_d      = alu_ill;
      flags_d        = alu_flags;
      if (in_op == OP_HALT) begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_hi_q       <= '0;
      out_hi_valid_q <= 1'b0;
      out_dest_q     <= '0;
      out_wb_en_q    <= 1'b0;
      flags_q        <= '0;
      halted_q       <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_hi_q       <= out_hi_d;
      out_hi_valid_q <= out_hi_valid_d;
      out_dest_q     <= out_dest_d;
      out_wb_en_q    <= out_wb_en_d;
      flags_q        <= flags_d;
      halted_q       <= halted_d;
      illegal_q      <= illegal_d;
    end
  end

`ifdef EXECUTE_MUL_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      msigned_q <= 1'b0;
      mdest_q   <= '0;
    end else begin
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      msigned_q <= msigned_d;
      mdest_q   <= mdest_d;
    end
  end
`endif

  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_result_hi = out_hi_q;
  assign out_hi_valid  = out_hi_valid_q;
  assign out_dest      = out_dest_q;
  assign out_wb_en     = out_wb_en_q;
  assign out_flags     = flags_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe at the default widths; results are checked at falling edges.
module tb_execute_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [3:0]  in_dest;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [63:0] out_result_hi;
  logic        out_hi_valid;
  logic [3:0]  out_dest;
  logic        out_wb_en;
  logic [3:0]  out_flags;
  logic        halted;
  logic        illegal;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  execute_pipe #(.DATA_WIDTH(64), .MUL_STEP_BITS(8), .REG_ADDR_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_result_hi(out_result_hi),
    .out_hi_valid(out_hi_valid), .out_dest(out_dest), .out_wb_en(out_wb_en),
    .out_flags(out_flags), .halted(halted), .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one op and return at the falling edge after it was accepted.
  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] dest);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_dest  = dest;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout: observed=%0d cycles required=<50", n);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL result_timeout: observed=%0d cycles required=<50", n);
    end
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = 4'd0;
    in_a      = '0;
    in_b      = '0;
    in_dest   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_result_hi", out_result_hi, 0);
    check("rst_flags", out_flags, 0);
    check("rst_halted", halted, 0);
    check("rst_wb_en", out_wb_en, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, 0);

    // ADD wrap, then ADC on the very next cycle sees CF=1
    send(4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3);
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 0);
    check("add_flags", out_flags, 4'b1100);
    check("add_wb", out_wb_en, 1);
    check("add_dest", out_dest, 3);
    check("add_illegal", illegal, 0);
    send(4'd2, 64'd5, 64'd5, 4'd4);
    check("adc_result", out_result, 64'hB);
    check("adc_flags", out_flags, 4'b0000);

    send(4'd5, 64'd3, 64'd7, 4'd1);
    check("cmp_wb", out_wb_en, 0);
    check("cmp_flags", out_flags, 4'b1010);
    send(4'd4, 64'd10, 64'd3, 4'd2);
    check("sbb_result", out_result, 64'd6);
    check("sbb_flags", out_flags, 4'b0000);
    send(4'd3, 64'h8000_0000_0000_0000, 64'd1, 4'd2);
    check("sub_result", out_result, 64'h7FFF_FFFF_FFFF_FFFF);
    check("sub_flags", out_flags, 4'b0001);
    send(4'd9, 64'd0, 64'd0, 4'd2);
    check("not_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("not_flags", out_flags, 4'b0001);
    send(4'd6, 64'hF0, 64'h0F, 4'd2);
    check("and_result", out_result, 0);
    check("and_flags", out_flags, 4'b0100);
    send(4'd10, 64'd5, 64'd0, 4'd2);
    check("neg_result", out_result, 64'hFFFF_FFFF_FFFF_FFFB);
    check("neg_flags", out_flags, 4'b1010);
    send(4'd11, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'd2);
    check("inc_result", out_result, 64'h8000_0000_0000_0000);
    check("inc_flags", out_flags, 4'b1011);
    send(4'd12, 64'd1, 64'd0, 4'd2);
    check("dec_result", out_result, 0);
    check("dec_flags", out_flags, 4'b1100);
    send(4'd0, 64'd123, 64'h42, 4'd6);
    check("mov_result", out_result, 64'h42);
    check("mov_flags", out_flags, 4'b1100);
    check("mov_dest", out_dest, 6);
    send(4'd7, 64'h8000_0000_0000_0000, 64'd0, 4'd2);
    check("or_result", out_result, 64'h8000_0000_0000_0000);
    check("or_flags", out_flags, 4'b0010);

    // Back-pressure: one XOR accepted, further offers held off while out_ready=0
    @(negedge clk);
    check("drain_valid", out_valid, 0);
    out_ready = 1'b0;
    send(4'd8, 64'hFF, 64'h0F, 4'd5);
    check("bp_first_result", out_result, 64'hF0);
    check("bp_first_flags", out_flags, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 4'd8;
      in_a     = 64'(i + 2);
      in_b     = 64'd3;
      in_dest  = 4'd7;
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_result", out_result, 64'hF0);
      check("bp_hold_dest", out_dest, 5);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    send(4'd8, 64'd1, 64'd1, 4'd7);
    check("bp_next_result", out_result, 0);
    check("bp_next_flags", out_flags, 4'b0100);
    check("bp_next_dest", out_dest, 7);

`ifdef EXECUTE_MUL_EN
    in_valid = 1'b1;
    in_op    = 4'd14;
    in_a     = 64'hFFFF_FFFF_FFFF_FFFD;
    in_b     = 64'd5;
    in_dest  = 4'd8;
    @(negedge clk);
    in_valid = 1'b0;
    check("imul_busy_state", dbg_state, 1);
    check("imul_busy_valid", out_valid, 0);
    n = 0;
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("imul_stall_cycles", n, 9);
    check("imul_valid", out_valid, 1);
    check("imul_lo", out_result, 64'hFFFF_FFFF_FFFF_FFF1);
    check("imul_hi", out_result_hi, 64'hFFFF_FFFF_FFFF_FFFF);
    check("imul_hi_valid", out_hi_valid, 1);
    check("imul_flags", out_flags, 4'b0010);
    check("imul_dest", out_dest, 8);
    send(4'd13, 64'h8000_0000_0000_0000, 64'd4, 4'd9);
    wait_valid();
    check("mul_lo", out_result, 0);
    check("mul_hi", out_result_hi, 64'd2);
    check("mul_flags", out_flags, 4'b1101);
    check("mul_hi_valid", out_hi_valid, 1);
    send(4'd0, 64'd0, 64'd9, 4'd1);
    check("post_mul_hi_valid", out_hi_valid, 0);
    check("post_mul_hi", out_result_hi, 0);
    check("post_mul_flags", out_flags, 4'b1101);
    // Reset during the fourth multiply cycle
    send(4'd13, 64'd7, 64'd9, 4'd1);
    repeat (3) @(negedge clk);
    check("mul_mid_state", dbg_state, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_flags", out_flags, 0);
    check("midrst_state", dbg_state, 0);
`else
    send(4'd14, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 4'd8);
    check("imul_ill_valid", out_valid, 1);
    check("imul_ill_flag", illegal, 1);
    check("imul_ill_result", out_result, 0);
    check("imul_ill_wb", out_wb_en, 0);
    check("imul_ill_hi_valid", out_hi_valid, 0);
    check("imul_ill_flags", out_flags, 4'b0100);
    send(4'd1, 64'd1, 64'd1, 4'd2);
    check("post_ill_illegal", illegal, 0);
    check("post_ill_result", out_result, 64'd2);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_flags", out_flags, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    send(4'd0, 64'd0, 64'h42, 4'd2);
    check("postrst_mov", out_result, 64'h42);
    check("postrst_illegal", illegal, 0);

    send(4'd15, 64'd0, 64'd0, 4'd0);
    check("halt_halted", halted, 1);
    check("halt_valid", out_valid, 1);
    check("halt_wb", out_wb_en, 0);
    check("halt_in_ready", in_ready, 0);
    check("halt_state", dbg_state, 2);
    in_valid = 1'b1;
    in_op    = 4'd0;
    in_b     = 64'h99;
    repeat (3) @(negedge clk);
    check("halt_in_ready_hold", in_ready, 0);
    check("halt_sticky", halted, 1);
    check("halt_drained", out_valid, 0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
